// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding wait-stated load/store responder over a 128-word memory.
// Optional misaligned-access error reporting under `DMEM_MISALIGN_ERR_EN.
module data_mem_responder #(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_req_be,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic                    o_busy
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q;
    logic [9:0]            addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [BE_W-1:0]       be_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] mem_q [128];
    logic                  accept;
    logic                  misalign;
    logic                  unused_addr;

    // Only bits [9:0] select storage; the rest wrap away.
    assign unused_addr = ^i_req_addr;

`ifdef DMEM_MISALIGN_ERR_EN
    assign misalign = |addr_q[2:0];
`else
    assign misalign = 1'b0;
`endif

    assign accept      = (state_q == IDLE) && i_req_valid;
    assign o_req_ready = (state_q == IDLE);
    assign o_rsp_valid = (state_q == RESP);
    assign o_busy      = (state_q != IDLE);
    assign o_rsp_rdata = rdata_q;
    assign o_rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (i_req_valid) begin
                    state_d = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                    cnt_d   = WAIT_INIT;
                end
            end
            WAIT: begin
                state_d = (cnt_q == 4'd0) ? ACCESS : WAIT;
                cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
            end
            ACCESS:  state_d = RESP;
            default: state_d = i_rsp_ready ? IDLE : RESP;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= i_req_we;
                addr_q  <= i_req_addr[9:0];
                wdata_q <= i_req_wdata;
                be_q    <= i_req_be;
            end
            if (state_q == ACCESS) begin
                rdata_q <= (we_q || misalign) ? '0 : mem_q[addr_q[9:3]];
                err_q   <= misalign;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            for (int i = 0; i < 128; i++) mem_q[i] <= '0;
        end else if (state_q == ACCESS && we_q && !misalign) begin
            for (int b = 0; b < BE_W; b++)
                if (be_q[b]) mem_q[addr_q[9:3]][b*8 +: 8] <= wdata_q[b*8 +: 8];
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed scoreboard bench for data_mem_responder.
module tb_data_mem_responder;
    localparam int WAIT_CYCLES = 2;

    typedef struct packed {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_arst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [63:0] i_req_addr = '0;
    logic [63:0] i_req_wdata = '0;
    logic [7:0]  i_req_be = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [63:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_busy;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    logic prev_valid = 1'b0;

    data_mem_responder #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .WAIT_CYCLES(WAIT_CYCLES)) dut (
        .i_clk(i_clk), .i_arst(i_arst), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata), .i_req_be(i_req_be),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_err(o_rsp_err), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: each new response is compared against the oldest expectation.
    always @(negedge i_clk) begin
        if (o_rsp_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rdata 0x%0h with no pending request", o_rsp_rdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_rdata", o_rsp_rdata, e.rdata);
                chk("rsp_err", 64'(o_rsp_err), 64'(e.err));
            end
        end
        prev_valid = o_rsp_valid;
    end

    task automatic xact(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] be, input logic [63:0] exp_rd, input logic exp_err,
                        input int hold);
        int lat;
        @(negedge i_clk);
        i_req_valid = 1'b1;
        i_req_we    = we;
        i_req_addr  = addr;
        i_req_wdata = wdata;
        i_req_be    = be;
        chk("req_ready_idle", 64'(o_req_ready), 64'd1);
        @(posedge i_clk);
        sb.push_back('{rdata: exp_rd, err: exp_err});
        @(negedge i_clk);
        // Scramble the request inputs mid-transaction; they must be ignored.
        i_req_valid = 1'b0;
        i_req_we    = ~we;
        i_req_addr  = addr ^ 64'h28;
        i_req_wdata = ~wdata;
        i_req_be    = ~be;
        lat = 1;
        while (!o_rsp_valid && lat < 50) begin
            @(negedge i_clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(WAIT_CYCLES + 2));
        for (int i = 0; i < hold; i++) begin
            i_req_valid = 1'b1;
            chk("hold_valid", 64'(o_rsp_valid), 64'd1);
            chk("hold_rdata", o_rsp_rdata, exp_rd);
            chk("hold_req_ready", 64'(o_req_ready), 64'd0);
            @(negedge i_clk);
        end
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
        chk("done_valid", 64'(o_rsp_valid), 64'd0);
        chk("done_busy", 64'(o_busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        #1;
        chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("rst_rdata", o_rsp_rdata, 64'd0);
        chk("rst_err", 64'(o_rsp_err), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        repeat (2) @(negedge i_clk);
        i_arst = 1'b0;
        #1;
        chk("rst_req_ready", 64'(o_req_ready), 64'd1);

        xact(1'b0, 64'h40, 64'h0, 8'h00, 64'h0, 1'b0, 0);
        xact(1'b1, 64'h18, 64'h1122334455667788, 8'hFF, 64'h0, 1'b0, 0);
        xact(1'b0, 64'h18, 64'h0, 8'h00, 64'h1122334455667788, 1'b0, 0);
        xact(1'b0, 64'h418, 64'h0, 8'h00, 64'h1122334455667788, 1'b0, 0);
        xact(1'b1, 64'h18, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 1'b0, 0);
        xact(1'b0, 64'h18, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0, 5);

        // Store to 0x20 abandoned by reset while waiting.
        @(negedge i_clk);
        i_req_valid = 1'b1;
        i_req_we    = 1'b1;
        i_req_addr  = 64'h20;
        i_req_wdata = 64'hDEADBEEFCAFEF00D;
        i_req_be    = 8'hFF;
        @(negedge i_clk);
        i_req_valid = 1'b0;
        chk("wait_busy", 64'(o_busy), 64'd1);
        i_arst = 1'b1;
        #1;
        chk("arst_busy", 64'(o_busy), 64'd0);
        chk("arst_valid", 64'(o_rsp_valid), 64'd0);
        repeat (2) @(negedge i_clk);
        i_arst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(o_req_ready), 64'd1);
        repeat (6) @(negedge i_clk);
        chk("no_rsp_after_rst", 64'(o_rsp_valid), 64'd0);

        xact(1'b0, 64'h20, 64'h0, 8'h00, 64'h0, 1'b0, 0);
        xact(1'b0, 64'h18, 64'h0, 8'h00, 64'h0, 1'b0, 0);
`ifdef DMEM_MISALIGN_ERR_EN
        xact(1'b1, 64'h1C, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b1, 0);
        xact(1'b0, 64'h18, 64'h0, 8'h00, 64'h0, 1'b0, 0);
`else
        xact(1'b1, 64'h1C, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0, 0);
        xact(1'b0, 64'h18, 64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b0, 0);
`endif
        repeat (2) @(negedge i_clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
